// File: rtl/pointconv_accum.sv
`default_nettype none
// ============================================================================
//  Module   : pointconv_accum
//  Purpose  : Accumulates pointwise-convolution partial products across all
//             input maps into a per-position buffer, then streams the
//             finished output-map vectors in position order under a
//             valid/ready handshake.
//  Revision : 1.0  initial release
//
//  Ports
//    clk             in   single clock, posedge
//    reset           in   synchronous, active-high
//    valid_in        in   partial-product beat present
//    indata          in   [LANES][DW] partial products for one position
//    inposition      in   32-bit position of the beat
//    inmap_in        in   5-bit input-map index of the beat
//    numOfInmaps     in   6-bit input maps per layer (1..32)
//    numOfPositions  in   7-bit positions per layer (1..DEPTH)
//    layer_done_in   in   upstream layer finished
//    ready_in        in   downstream accepts the output beat
//    outdata         out  [LANES][DW] accumulated result
//    outposition     out  32-bit zero-extended position of outdata
//    valid_out       out  outdata/outposition valid
//    rdy             out  block can accept beats
//    layer_done_out  out  sticky layer-complete flag
//    err             out  sticky: a beat was dropped
//
//  Build option
//    ACCUM_SATURATE_EN  when defined, lane adds saturate to signed DW-bit
//                       limits; otherwise they wrap modulo 2^DW.
// ============================================================================
module pointconv_accum #(
  parameter int DEPTH = 64,
  parameter int LANES = 8,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [LANES-1:0][DW-1:0] indata,
  input  logic [31:0]              inposition,
  input  logic [4:0]               inmap_in,
  input  logic [5:0]               numOfInmaps,
  input  logic [6:0]               numOfPositions,
  input  logic                     layer_done_in,
  input  logic                     ready_in,
  output logic [LANES-1:0][DW-1:0] outdata,
  output logic [31:0]              outposition,
  output logic                     valid_out,
  output logic                     rdy,
  output logic                     layer_done_out,
  output logic                     err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [LANES-1:0][DW-1:0] r_buf [DEPTH];
  logic [6:0]               r_lastcnt;
  logic [AW-1:0]            r_rdcnt;
  logic [LANES-1:0][DW-1:0] r_outdata;
  logic                     r_valid_out;
  logic                     r_err;
  logic                     r_ld;
  logic                     r_ld_pend;

  logic [AW-1:0]            w_addr;
  logic                     w_in_range;
  logic                     w_accept;
  logic                     w_drop;
  logic                     w_is_last_map;
  logic [6:0]               w_lastcnt_inc;
  logic                     w_layer_in;
  logic                     w_drain_end;
  logic [AW-1:0]            w_rdcnt_inc;
  logic [LANES-1:0][DW-1:0] w_cur;
  logic [LANES-1:0][DW-1:0] w_sum;

  // ---------------------------------------------------------------- beat qualify
  assign w_addr        = inposition[AW-1:0];
  // Full 32-bit compare so high position bits cannot alias into the buffer.
  assign w_in_range    = inposition < 32'(numOfPositions);
  assign w_accept      = valid_in && rdy && w_in_range;
  assign w_drop        = valid_in && !w_accept;
  assign w_is_last_map = ({1'b0, inmap_in} == (numOfInmaps - 6'd1));
  assign w_lastcnt_inc = r_lastcnt + 7'd1;
  // Final beat of the layer: the edge that accepts it also enters DRAIN.
  assign w_layer_in    = w_accept && w_is_last_map && (w_lastcnt_inc == numOfPositions);
  assign w_drain_end   = r_valid_out && ready_in && (7'(r_rdcnt) == (numOfPositions - 7'd1));
  assign w_rdcnt_inc   = r_rdcnt + AW'(1);

  // ---------------------------------------------------------------- lane adders
  // Asynchronous read feeds the adders so a beat to the same address on the
  // very next cycle sees the value written on the previous edge.
  assign w_cur = r_buf[w_addr];

  always_comb begin
    w_sum = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef ACCUM_SATURATE_EN
      logic [DW-1:0] v_raw;
      v_raw = w_cur[l] + indata[l];
      // Signed overflow only when both operands share a sign the result lacks.
      if ((w_cur[l][DW-1] == indata[l][DW-1]) && (v_raw[DW-1] != w_cur[l][DW-1]))
        w_sum[l] = w_cur[l][DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
        w_sum[l] = v_raw;
`else
      w_sum[l] = w_cur[l] + indata[l];
`endif
    end
  end

  // ---------------------------------------------------------------- buffer
  always_ff @(posedge clk) begin
    if (!reset && w_accept)
      r_buf[w_addr] <= (inmap_in == 5'd0) ? indata : w_sum;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_layer_in)    w_state_nxt = S_DRAIN;
        else if (valid_in) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: if (w_layer_in)  w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drain_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rdy = 1'b0;
    if (r_state == S_IDLE || r_state == S_ACCUM) rdy = 1'b1;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastcnt   <= '0;
      r_rdcnt     <= '0;
      r_outdata   <= '0;
      r_valid_out <= 1'b0;
      r_err       <= 1'b0;
      r_ld        <= 1'b0;
      r_ld_pend   <= 1'b0;
    end else begin
      if (w_drop) r_err <= 1'b1;

      if (w_layer_in)                        r_lastcnt <= '0;
      else if (w_accept && w_is_last_map)    r_lastcnt <= w_lastcnt_inc;

      if (r_state == S_DRAIN) begin
        if (!r_valid_out) begin
          // First DRAIN cycle: present position 0.
          r_outdata   <= r_buf[r_rdcnt];
          r_valid_out <= 1'b1;
        end else if (ready_in) begin
          if (w_drain_end) begin
            r_valid_out <= 1'b0;
            r_rdcnt     <= '0;
          end else begin
            r_rdcnt   <= w_rdcnt_inc;
            r_outdata <= r_buf[w_rdcnt_inc];
          end
        end
      end

      // layer_done seen while busy is deferred until the FSM returns to IDLE.
      if (layer_done_in && r_state != S_IDLE) r_ld_pend <= 1'b1;
      if (layer_done_in && r_state == S_IDLE) r_ld      <= 1'b1;
      if (w_drain_end && (r_ld_pend || layer_done_in)) begin
        r_ld      <= 1'b1;
        r_ld_pend <= 1'b0;
      end
    end
  end

  assign outdata        = r_outdata;
  assign outposition    = 32'(r_rdcnt);
  assign valid_out      = r_valid_out;
  assign layer_done_out = r_ld;
  assign err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pointconv_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pointconv_accum
//  Purpose  : Self-checking bench for pointconv_accum. A per-position
//             arithmetic model tracks the expected buffer contents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pointconv_accum;

  localparam int DEPTH = 64;
  localparam int LANES = 8;
  localparam int DW    = 32;

  typedef logic [LANES-1:0][DW-1:0] vec_t;

  logic        clk            = 1'b0;
  logic        reset          = 1'b1;
  logic        valid_in       = 1'b0;
  vec_t        indata         = '0;
  logic [31:0] inposition     = '0;
  logic [4:0]  inmap_in       = '0;
  logic [5:0]  numOfInmaps    = 6'd1;
  logic [6:0]  numOfPositions = 7'd1;
  logic        layer_done_in  = 1'b0;
  logic        ready_in       = 1'b0;
  vec_t        outdata;
  logic [31:0] outposition;
  logic        valid_out;
  logic        rdy;
  logic        layer_done_out;
  logic        err;

  pointconv_accum #(.DEPTH(DEPTH), .LANES(LANES), .DW(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .indata         (indata),
    .inposition     (inposition),
    .inmap_in       (inmap_in),
    .numOfInmaps    (numOfInmaps),
    .numOfPositions (numOfPositions),
    .layer_done_in  (layer_done_in),
    .ready_in       (ready_in),
    .outdata        (outdata),
    .outposition    (outposition),
    .valid_out      (valid_out),
    .rdy            (rdy),
    .layer_done_out (layer_done_out),
    .err            (err)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [DW-1:0] mdl [DEPTH][LANES];
  bit          exp_err    = 1'b0;
  bit          exp_ld     = 1'b0;
  bit          ld_pending = 1'b0;
  vec_t        expq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed sum computed in 64 bits, then wrapped or clamped to DW bits.
  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef ACCUM_SATURATE_EN
    if (s > 64'sd2147483647)       s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[DW-1:0];
  endfunction

  task automatic model_beat(input logic [31:0] pos, input int map, input vec_t d);
    if (pos >= 32'(numOfPositions)) begin
      exp_err = 1'b1;
    end else begin
      for (int l = 0; l < LANES; l++)
        mdl[pos[5:0]][l] = (map == 0) ? d[l] : lane_add(mdl[pos[5:0]][l], d[l]);
    end
  endtask

  task automatic send_beat(input logic [31:0] pos, input int map, input vec_t d);
    valid_in   = 1'b1;
    inposition = pos;
    inmap_in   = 5'(map);
    indata     = d;
    model_beat(pos, map, d);
    tick();
    valid_in   = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    tick();
    tick();
    reset      = 1'b0;
    exp_err    = 1'b0;
    exp_ld     = 1'b0;
    ld_pending = 1'b0;
  endtask

  // dmode 0: 100m+10p+l in position order; 1: random data/order with gaps;
  // 2: constant 5 on consecutive cycles.
  task automatic run_layer(input int np, input int nm, input int dmode);
    numOfPositions = 7'(np);
    numOfInmaps    = 6'(nm);
    for (int m = 0; m < nm; m++) begin
      int perm[$];
      for (int p = 0; p < np; p++) perm.push_back(p);
      if (dmode == 1) begin
        for (int i = np - 1; i > 0; i--) begin
          int j;
          int t;
          j = int'($urandom_range(i, 0));
          t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
      end
      for (int k = 0; k < np; k++) begin
        vec_t d;
        for (int l = 0; l < LANES; l++) begin
          case (dmode)
            0:       d[l] = 32'(100 * m + 10 * perm[k] + l);
            1:       d[l] = $urandom;
            default: d[l] = 32'd5;
          endcase
        end
        if (dmode == 1 && $urandom_range(3, 0) == 0) tick();
        send_beat(32'(perm[k]), m, d);
      end
    end
    chk("rdy_drain_entry", rdy, 1'b0);
    chk("valid_drain_entry", valid_out, 1'b0);
  endtask

  task automatic fill_from_model(input int np);
    expq.delete();
    for (int p = 0; p < np; p++) begin
      vec_t v;
      for (int l = 0; l < LANES; l++) v[l] = mdl[p][l];
      expq.push_back(v);
    end
  endtask

  // rmode 0: ready high; 1: random ready; 2: ready pattern 1,0,0,1.
  // inject: pulse valid_in mid-drain and on the final handshake.
  task automatic drain(input int np, input int rmode, input bit inject);
    int got = 0;
    int cyc = 0;
    int k   = 0;
    logic [3:0] pat = 4'b1001;
    while (got < np && cyc < 6 * np + 20) begin
      case (rmode)
        0:       ready_in = 1'b1;
        1:       ready_in = 1'($urandom_range(1, 0));
        default: ready_in = pat[3 - (k % 4)];
      endcase
      chk("ld_during_drain", layer_done_out, exp_ld);
      chk("rdy_during_drain", rdy, 1'b0);
      if (valid_out) begin
        chk("outposition", outposition, 32'(got));
        for (int l = 0; l < LANES; l++)
          chk($sformatf("outdata_p%0d_l%0d", got, l), outdata[l], expq[got][l]);
        k++;
      end
      if (inject && (cyc == 2 || (valid_out && ready_in && got == np - 1))) begin
        valid_in   = 1'b1;
        inposition = 32'd0;
        inmap_in   = 5'd1;
        indata     = {LANES{$urandom}};
        exp_err    = 1'b1;
      end
      if (valid_out && ready_in) got++;
      tick();
      cyc++;
      valid_in = 1'b0;
    end
    chk("drain_count", 32'(got), 32'(np));
    if (rmode == 0) chk("drain_cycles", 32'(cyc), 32'(np + 1));
    if (ld_pending) exp_ld = 1'b1;
    ld_pending = 1'b0;
    chk("valid_after_drain", valid_out, 1'b0);
    chk("rdy_after_drain", rdy, 1'b1);
    chk("err_after_drain", err, exp_err);
    chk("ld_after_drain", layer_done_out, exp_ld);
    ready_in = 1'b0;
  endtask

  initial begin
    int np;
    int nm;
    vec_t v;

    // ---- reset state
    do_reset();
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_outposition", outposition, 32'd0);
    for (int l = 0; l < LANES; l++) chk($sformatf("rst_outdata_l%0d", l), outdata[l], 32'd0);
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_layer_done", layer_done_out, 1'b0);
    chk("rst_err", err, 1'b0);

    // ---- basic accumulation, expected lane = sum over m of (100m+10p+l)
    run_layer(4, 3, 0);
    expq.delete();
    for (int p = 0; p < 4; p++) begin
      for (int l = 0; l < LANES; l++) v[l] = 32'(300 + 30 * p + 3 * l);
      expq.push_back(v);
    end
    drain(4, 0, 1'b0);

    // ---- back-to-back beats to one position: 4 x 5 = 20
    run_layer(1, 4, 2);
    expq.delete();
    for (int l = 0; l < LANES; l++) v[l] = 32'd20;
    expq.push_back(v);
    drain(1, 0, 1'b0);

    // ---- backpressure pattern 1,0,0,1
    run_layer(4, 2, 1);
    fill_from_model(4);
    drain(4, 2, 1'b0);

    // ---- randomized layers with random backpressure
    for (int t = 0; t < 3; t++) begin
      np = int'($urandom_range(16, 2));
      nm = int'($urandom_range(5, 1));
      run_layer(np, nm, 1);
      fill_from_model(np);
      drain(np, 1, 1'b0);
    end

    // ---- full buffer depth
    run_layer(DEPTH, 2, 1);
    fill_from_model(DEPTH);
    drain(DEPTH, 0, 1'b0);

    // ---- dropped beats: out-of-range position, valid_in during DRAIN
    numOfPositions = 7'd8;
    numOfInmaps    = 6'd2;
    for (int p = 0; p < 8; p++) begin
      for (int l = 0; l < LANES; l++) v[l] = $urandom;
      send_beat(32'(p), 0, v);
    end
    chk("err_before_drop", err, 1'b0);
    for (int l = 0; l < LANES; l++) v[l] = $urandom;
    send_beat(32'd70, 1, v);
    chk("err_after_range_drop", err, 1'b1);
    for (int p = 0; p < 8; p++) begin
      for (int l = 0; l < LANES; l++) v[l] = $urandom;
      send_beat(32'(p), 1, v);
    end
    chk("rdy_err_drain_entry", rdy, 1'b0);
    fill_from_model(8);
    drain(8, 1, 1'b1);

    // ---- overflow on lane 0
    numOfPositions = 7'd1;
    numOfInmaps    = 6'd2;
    for (int l = 0; l < LANES; l++) v[l] = $urandom;
    v[0] = 32'h7FFF_FFFF;
    send_beat(32'd0, 0, v);
    for (int l = 0; l < LANES; l++) v[l] = $urandom;
    v[0] = 32'h7FFF_FFFF;
    send_beat(32'd0, 1, v);
    fill_from_model(1);
    v = expq[0];
`ifdef ACCUM_SATURATE_EN
    v[0] = 32'h7FFF_FFFF;
`else
    v[0] = 32'hFFFF_FFFE;
`endif
    expq[0] = v;
    drain(1, 0, 1'b0);

    // ---- reset asserted mid-DRAIN
    run_layer(4, 1, 1);
    ready_in = 1'b1;
    tick();
    tick();
    chk("valid_mid_drain", valid_out, 1'b1);
    reset = 1'b1;
    tick();
    chk("valid_after_mid_reset", valid_out, 1'b0);
    chk("rdy_after_mid_reset", rdy, 1'b1);
    chk("err_after_mid_reset", err, 1'b0);
    reset    = 1'b0;
    ready_in = 1'b0;
    exp_err  = 1'b0;
    tick();
    chk("valid_stays_low", valid_out, 1'b0);

    // ---- layer_done_in sampled in IDLE
    do_reset();
    chk("ld_idle_before", layer_done_out, 1'b0);
    layer_done_in = 1'b1;
    tick();
    layer_done_in = 1'b0;
    chk("ld_idle_set", layer_done_out, 1'b1);
    tick();
    chk("ld_idle_sticky", layer_done_out, 1'b1);

    // ---- layer_done_in sampled in ACCUM, deferred to IDLE
    do_reset();
    numOfPositions = 7'd2;
    numOfInmaps    = 6'd1;
    for (int l = 0; l < LANES; l++) v[l] = $urandom;
    send_beat(32'd0, 0, v);
    layer_done_in = 1'b1;
    tick();
    layer_done_in = 1'b0;
    ld_pending    = 1'b1;
    chk("ld_accum_deferred", layer_done_out, 1'b0);
    for (int l = 0; l < LANES; l++) v[l] = $urandom;
    send_beat(32'd1, 0, v);
    chk("ld_drain_entry", layer_done_out, 1'b0);
    fill_from_model(2);
    drain(2, 0, 1'b0);
    tick();
    tick();
    chk("ld_accum_sticky", layer_done_out, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
